// File: rtl/dds_demod_ctrl.sv
// dds_demod_ctrl: receive-side phase demodulator for the DDS phase-modulation link.
// Stamps each rising edge of the sliced carrier against a free-running local
// carrier-phase counter. It votes per quadrant over one symbol period and emits
// the majority quadrant as {S,P} one cycle after the symbol strobe.
// Optional build macro: DDS_DEMOD_GRAY_EN (Gray-decode the winning quadrant).
module dds_demod_ctrl #(
    parameter int PHASE_W = 4,
    parameter int VOTE_W  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    input  logic cout,
    output logic P,
    output logic S,
    output logic valid,
    output logic no_edge
);

    // An edge is seen two clocks after the first synchronizer flop samples it.
    localparam int                SYNC_LAT = 2;
    localparam logic [VOTE_W-1:0] VOTE_MAX = '1;

    typedef enum logic {
        ALIGN = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [PHASE_W-1:0] phase_cnt_reg;
    logic               sync1_reg, sync2_reg, hist_reg;
    logic [VOTE_W-1:0]  vote_reg  [4];
    logic [VOTE_W-1:0]  vote_inc  [4];
    logic [VOTE_W-1:0]  vote_next [4];
    logic [VOTE_W-1:0]  best_vote;
    logic               p_reg, p_next;
    logic               s_reg, s_next;
    logic               valid_reg, valid_next;
    logic               no_edge_reg, no_edge_next;
    logic               edge_det;
    logic               any_vote;
    logic [PHASE_W-1:0] stamp;
    logic [1:0]         quad;
    logic [1:0]         winner;
    logic [1:0]         sym;        // {S,P} for the winning quadrant

    // Free-running local carrier phase; only reset restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt_reg <= '0;
        end else begin
            phase_cnt_reg <= phase_cnt_reg + PHASE_W'(1);
        end
    end

    // Two-flop synchronizer plus one history flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            hist_reg  <= 1'b0;
        end else begin
            sync1_reg <= sig;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    assign edge_det = sync2_reg & ~hist_reg;
    // Back off the synchronizer delay so the stamp is the phase at first capture.
    assign stamp    = phase_cnt_reg - PHASE_W'(SYNC_LAT);
    assign quad     = 2'(stamp >> (PHASE_W - 2));

    // Per-quadrant saturating increment, including an edge in the current cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_vote_inc
            assign vote_inc[gi] = (edge_det && (quad == 2'(gi)) && (vote_reg[gi] != VOTE_MAX))
                                ? vote_reg[gi] + VOTE_W'(1)
                                : vote_reg[gi];
        end
    endgenerate

    // Majority quadrant; strict compare keeps ties on the lowest quadrant.
    always_comb begin
        winner    = 2'd0;
        best_vote = vote_inc[0];
        for (int i = 1; i < 4; i++) begin
            if (vote_inc[i] > best_vote) begin
                best_vote = vote_inc[i];
                winner    = 2'(i);
            end
        end
        any_vote = ((vote_inc[0] | vote_inc[1] | vote_inc[2] | vote_inc[3]) != '0);
    end

`ifdef DDS_DEMOD_GRAY_EN
    // Gray decode: adjacent quadrants differ in one output bit.
    assign sym = {winner[1], winner[1] ^ winner[0]};
`else
    // Direct binary: q -> {S,P} = q.
    assign sym = winner;
`endif

    // Next-state, vote update and decision outputs.
    always_comb begin
        state_next   = state_reg;
        p_next       = p_reg;
        s_next       = s_reg;
        valid_next   = 1'b0;
        no_edge_next = no_edge_reg;
        for (int i = 0; i < 4; i++) begin
            vote_next[i] = vote_inc[i];
        end
        case (state_reg)
            ALIGN: begin
                for (int i = 0; i < 4; i++) begin
                    vote_next[i] = '0;
                end
                if (cout) begin
                    state_next = TRACK;
                end
            end
            TRACK: begin
                if (cout) begin
                    valid_next = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        vote_next[i] = '0;
                    end
                    if (any_vote) begin
                        p_next       = sym[0];
                        s_next       = sym[1];
                        no_edge_next = 1'b0;
                    end else begin
                        no_edge_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ALIGN;
            end
        endcase
    end

    // State, vote and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ALIGN;
            p_reg       <= 1'b0;
            s_reg       <= 1'b0;
            valid_reg   <= 1'b0;
            no_edge_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                vote_reg[i] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            p_reg       <= p_next;
            s_reg       <= s_next;
            valid_reg   <= valid_next;
            no_edge_reg <= no_edge_next;
            for (int i = 0; i < 4; i++) begin
                vote_reg[i] <= vote_next[i];
            end
        end
    end

    assign P       = p_reg;
    assign S       = s_reg;
    assign valid   = valid_reg;
    assign no_edge = no_edge_reg;

endmodule

// File: tb/tb_dds_demod_ctrl.sv
// tb_dds_demod_ctrl: directed test of the DDS phase demodulator (PHASE_W=4).
// Symbols are 8 carrier periods aligned to local phase 0; the strobe sits on phase 15.
// In each period, sig rises at the chosen stamp and falls before phase 15.
module tb_dds_demod_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig = 1'b0;
    logic cout = 1'b0;
    logic P, S, valid, no_edge;

    logic [3:0] phase_model = 4'd0;

    int n_chk = 0;
    int n_err = 0;
    int vcount = 0;
    int exp_vcount = 0;
    int s_valid, s_p, s_s, s_ne;
    int last_ph = 0;

    dds_demod_ctrl #(.PHASE_W(4), .VOTE_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .sig     (sig),
        .cout    (cout),
        .P       (P),
        .S       (S),
        .valid   (valid),
        .no_edge (no_edge)
    );

    always #5 clk = ~clk;

    // Local phase as defined for the receiver: zero under reset, +1 per clock.
    always @(posedge clk) begin
        if (rst) phase_model <= 4'd0;
        else     phase_model <= phase_model + 4'd1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected {S,P} for a winning quadrant.
    function automatic logic [1:0] map_q(input int q);
        logic [1:0] t;
        t = 2'(q);
`ifdef DDS_DEMOD_GRAY_EN
        case (t)
            2'd0: return 2'b00;
            2'd1: return 2'b01;
            2'd2: return 2'b11;
            default: return 2'b10;
        endcase
`else
        return t;
`endif
    endfunction

    // One clock: sample the outputs at the falling edge, then drive the next inputs.
    task automatic cyc(input logic c, input int st);
        @(negedge clk);
        s_valid = int'(valid);
        s_p     = int'(P);
        s_s     = int'(S);
        s_ne    = int'(no_edge);
        if (valid) vcount++;
        last_ph = int'(phase_model);
        cout    = c;
        sig     = (st >= 0) && (last_ph >= st) && (last_ph <= st + 7) && (last_ph != 15);
    endtask

    task automatic pad();
        do cyc(1'b0, -1); while (last_ph != 15);
    endtask

    task automatic period(input int st, input logic c_last);
        for (int i = 0; i < 16; i++) cyc((i == 15) ? c_last : 1'b0, st);
    endtask

    task automatic symbol(input int st_a, input int n_a, input int st_b, input int n_b);
        for (int p = 0; p < 8; p++) begin
            period((p < n_a) ? st_a : ((p < n_a + n_b) ? st_b : -1), p == 7);
        end
    endtask

    // Cycle after the strobe: check the decision, then realign to phase 0.
    task automatic result(input string tag, input int ev, input int q, input int ne);
        logic [1:0] sp;
        sp = map_q(q);
        cyc(1'b0, -1);
        if (ev != 0) exp_vcount++;
        $display("[%0t] %s: valid=%0d S=%0d P=%0d no_edge=%0d", $time, tag, s_valid, s_s, s_p, s_ne);
        check({tag, " valid"}, s_valid, ev);
        check({tag, " P"}, s_p, int'(sp[0]));
        check({tag, " S"}, s_s, int'(sp[1]));
        check({tag, " no_edge"}, s_ne, ne);
        pad();
    endtask

    initial begin
        // Reset state after two reset cycles.
        cyc(1'b0, -1);
        cyc(1'b0, -1);
        cyc(1'b0, -1);
        $display("[%0t] reset: valid=%0d S=%0d P=%0d no_edge=%0d", $time, s_valid, s_s, s_p, s_ne);
        check("reset valid", s_valid, 0);
        check("reset P", s_p, 0);
        check("reset S", s_s, 0);
        check("reset no_edge", s_ne, 0);
        rst = 1'b0;
        pad();

        // Alignment strobe with sig toggling: no decision.
        symbol(4, 8, -1, 0);
        result("align", 0, 0, 0);
        check("align valid_count", vcount, exp_vcount);

        // Phase recovery for each quadrant.
        symbol(4, 8, -1, 0);   result("stamp4", 1, 1, 0);
        symbol(0, 8, -1, 0);   result("stamp0", 1, 0, 0);
        symbol(8, 8, -1, 0);   result("stamp8", 1, 2, 0);
        symbol(12, 8, -1, 0);  result("stamp12", 1, 3, 0);

        // Majority, then a tie between q1 and q3.
        symbol(9, 5, 1, 3);    result("majority", 1, 2, 0);
        symbol(5, 2, 13, 2);   result("tie", 1, 1, 0);

        // Empty symbol holds P/S.
        symbol(-1, 0, -1, 0);  result("empty", 1, 1, 1);

        // Edge coincident with the strobe belongs to the ending symbol.
        symbol(-1, 7, 13, 1);  result("coincident", 1, 3, 0);
        symbol(-1, 0, -1, 0);  result("after_coinc", 1, 3, 1);

        // Back-to-back strobes.
        cyc(1'b1, -1);
        cyc(1'b1, -1);
        cyc(1'b0, -1);
        exp_vcount++;
        $display("[%0t] b2b1: valid=%0d no_edge=%0d", $time, s_valid, s_ne);
        check("b2b1 valid", s_valid, 1);
        check("b2b1 no_edge", s_ne, 1);
        cyc(1'b0, -1);
        exp_vcount++;
        $display("[%0t] b2b2: valid=%0d no_edge=%0d", $time, s_valid, s_ne);
        check("b2b2 valid", s_valid, 0);
        pad();

        // Reset mid-symbol: partial votes discarded, back in ALIGN.
        period(12, 1'b0);
        period(12, 1'b0);
        period(12, 1'b0);
        rst = 1'b1;
        cyc(1'b0, -1);
        rst = 1'b0;
        pad();
        period(-1, 1'b1);
        result("rst_mid", 0, 0, 0);
        symbol(4, 8, -1, 0);   result("post_rst", 1, 1, 0);

        check("valid_count", vcount, exp_vcount);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dds_demod_ctrl.md
Name: dds_demod_ctrl

Overview:
- Receive-side counterpart of the DDS phase-modulation controller: recovers the 2-bit symbol (P, S) that selected the transmitted carrier phase.
- Inputs: a 1-bit sliced modulated carrier (`sig`) and the shared symbol strobe (`cout`).
- Measures the carrier phase of each rising edge of `sig` against a free-running local carrier-phase counter, then votes per symbol period.
- At each symbol boundary, emits the majority quadrant as P/S with a one-cycle valid pulse.

Parameters:
- PHASE_W, 4: local carrier-phase counter width; carrier period = 2^PHASE_W clk cycles; must be >= 2.
- VOTE_W, 8: width of each per-quadrant vote counter; counters saturate at 2^VOTE_W-1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- sig, input, 1: sliced modulated carrier, asynchronous to clk.
- cout, input, 1: symbol-boundary strobe, one clk cycle wide, same strobe that advances the transmitter.
- P, output, 1: recovered symbol bit 0 (registered).
- S, output, 1: recovered symbol bit 1 (registered).
- valid, output, 1: one-cycle pulse; P/S updated this cycle.
- no_edge, output, 1: registered; set when the last completed symbol contained zero `sig` edges.

Behaviour:
- Reset: synchronous and active-high. While rst=1 at a clk edge:
  - P=0, S=0, valid=0, no_edge=0.
  - phase_cnt=0, all vote counters=0, synchronizer flops=0, state=ALIGN.
- Reset asserted mid-symbol discards all partial votes. No valid is produced for that symbol.
- phase_cnt:
  - Increments by 1 every cycle and wraps modulo 2^PHASE_W.
  - Never reset by cout.
- Input conditioning:
  - `sig` passes through a 2-flop synchronizer plus one history flop.
  - A rising edge is one cycle with sync output 1 and history 0.
- Phase stamp:
  - The stamp is the phase_cnt value at the clk edge where `sig` is first sampled high by the first synchronizer flop.
  - The implementation compensates pipeline latency by subtracting the fixed delay, modulo 2^PHASE_W.
  - Quadrant q = top 2 bits of the stamp.
- Voting:
  - Each detected edge increments vote[q] by 1, saturating at max.
- FSM states:
  - ALIGN: votes ignored and held at 0; first cout -> TRACK; no valid.
  - TRACK: votes accumulate. On cout:
    - Decide winner = q with the largest vote; ties go to the lowest q.
    - Register P=winner[0], S=winner[1]; valid=1 on the next cycle.
    - Clear all votes in the same cycle. Remain in TRACK.
- Mapping: q0 -> P=0,S=0; q1 -> P=1,S=0; q2 -> P=0,S=1; q3 -> P=1,S=1. This is the inverse of the transmitter state order.
- Empty symbol: cout with all votes 0 gives valid=1, P/S hold their previous values, no_edge=1. Any non-empty decision clears no_edge.
- Simultaneous edge and cout in the same cycle: the edge is counted toward the ending symbol before the decision. The new symbol starts with all votes at 0.
- Back-to-back cout on consecutive cycles is legal. The second produces an empty symbol (no_edge=1).
- Latency: valid asserts 1 cycle after the cout cycle.

Optional Feature:
- Macro: DDS_DEMOD_GRAY_EN.
- When defined: the winner quadrant is Gray-decoded before output: q0 -> 00, q1 -> 01, q2 -> 11, q3 -> 10, giving {S,P}. A one-quadrant phase error then corrupts only one bit.
- When undefined: the direct binary mapping above applies. Port list is identical in both builds.

Test Plan:
- Reset + ALIGN: rst high 2 cycles, then cout once with sig toggling -> P=0, S=0, valid never pulses, no_edge=0.
- Phase recovery, PHASE_W=4:
  - Stimulus: sig a 16-cycle square wave whose rising edge lands at stamp 4; 8 carrier periods between couts (after alignment cout).
  - Required: valid pulses 1 cycle after cout with P=1, S=0. Repeat with stamps 0/8/12 -> 00/01(S=1,P=0)/11.
- Majority and tie:
  - 5 edges at stamp 9 and 3 at stamp 1 -> P=0, S=1.
  - 2 edges each at stamps 5 and 13 -> tie resolved to q1: P=1, S=0.
- Empty symbol and simultaneity:
  - Hold sig low across one symbol -> valid=1, P/S unchanged, no_edge=1.
  - Next symbol: an edge coincident with the cout cycle counts toward that symbol, and no_edge returns to 0.
- Reset mid-symbol: 3 edges at stamp 12, then rst for 1 cycle, then cout -> no valid (back in ALIGN). The following full symbol decodes correctly.
- Gray build (DDS_DEMOD_GRAY_EN defined): stamps 8 and 12 -> {S,P}=11 and 10 respectively.
